// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Imported by the fetch stage and its IF/ID register.
package cpu_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
  localparam logic [31:0] NOP_INSTR        = 32'hD503201F;

  typedef enum logic [1:0] {
    FETCH,
    WAIT_MEM,
    REDIRECT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Flush beats hold; load otherwise takes the new bundle.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.instr <= NOP_INSTR;
      q.pc    <= '0;
      q.valid <= 1'b0;
    end else if (flush) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, redirect FSM,
// flush counter and IF/ID register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 branch_taken,
  input  logic [63:0]          next_PC,
  input  logic                 stall,
  input  logic [31:0]          imem_rdata,
  input  logic                 imem_ready,
  output logic                 imem_req,
  output logic [63:0]          imem_addr,
  output logic [63:0]          PC,
  output logic [63:0]          PC_plus4,
  output logic [31:0]          if_id_instr,
  output logic [63:0]          if_id_PC,
  output logic                 if_id_valid,
  output logic                 fetch_misalign,
  output logic [CNT_WIDTH-1:0] flush_count
);

  fetch_state_t state, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  pend_q, pend_d;
  logic [63:0]  tgt;
  logic         load, flush, bump;
  if_id_t       ifid_d, ifid_q;

  assign tgt       = {next_PC[63:2], 2'b00};
  assign imem_req  = reset_n;
  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign PC_plus4  = pc_q + 64'd4;

  always_comb begin
    pc_d    = pc_q;
    pend_d  = pend_q;
    state_d = state;
    load    = 1'b0;
    flush   = 1'b0;
    bump    = 1'b0;
    unique case (state)
      FETCH: begin
        if (branch_taken) begin
          flush = 1'b1;
          bump  = 1'b1;
          if (imem_ready) begin
            pc_d = tgt;
          end else begin
            pend_d  = tgt;
            state_d = REDIRECT;
          end
        end else if (stall) begin
          pc_d = pc_q;
        end else if (imem_ready) begin
          load = 1'b1;
          pc_d = next_PC;
        end else begin
          flush   = 1'b1;
          state_d = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (branch_taken) begin
          flush   = 1'b1;
          bump    = 1'b1;
          pend_d  = tgt;
          state_d = REDIRECT;
        end else if (imem_ready) begin
          // a stalled return is dropped and refetched
          state_d = FETCH;
          if (!stall) begin
            load = 1'b1;
            pc_d = next_PC;
          end
        end else if (!stall) begin
          flush = 1'b1;
        end
      end
      REDIRECT: begin
        flush = 1'b1;
        if (branch_taken) begin
          bump = 1'b1;
          if (imem_ready) begin
            pc_d    = tgt;
            state_d = FETCH;
          end else begin
            pend_d = tgt;
          end
        end else if (imem_ready) begin
          pc_d    = pend_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= FETCH;
      pc_q           <= RESET_PC;
      pend_q         <= '0;
      fetch_misalign <= 1'b0;
      flush_count    <= '0;
    end else begin
      state  <= state_d;
      pc_q   <= pc_d;
      pend_q <= pend_d;
      if (branch_taken && next_PC[1:0] != 2'b00)
        fetch_misalign <= 1'b1;
      if (bump && flush_count != '1)
        flush_count <= flush_count + CNT_WIDTH'(1);
    end
  end

  assign ifid_d.instr = imem_rdata;
  assign ifid_d.pc    = pc_q;
  assign ifid_d.valid = 1'b1;

  if_id_reg u_if_id (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .flush   (flush),
    .d       (ifid_d),
    .q       (ifid_q)
  );

  assign if_id_instr = ifid_q.instr;
  assign if_id_PC    = ifid_q.pc;
  assign if_id_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a
// behavioural fetch model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'hD503201F;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          branch_taken = 1'b0;
  logic [63:0]   next_PC = '0;
  logic          stall = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          imem_ready = 1'b0;
  logic          imem_req;
  logic [63:0]   imem_addr, PC, PC_plus4, if_id_PC;
  logic [31:0]   if_id_instr;
  logic          if_id_valid, fetch_misalign;
  logic [CW-1:0] flush_count;

  fetch_unit #(.RESET_PC(64'h0), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .branch_taken   (branch_taken),
    .next_PC        (next_PC),
    .stall          (stall),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .PC             (PC),
    .PC_plus4       (PC_plus4),
    .if_id_instr    (if_id_instr),
    .if_id_PC       (if_id_PC),
    .if_id_valid    (if_id_valid),
    .fetch_misalign (fetch_misalign),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] m_pc, m_pend, m_ipc;
  logic [31:0] m_instr;
  logic        m_valid, m_mis, m_wait, m_redir;
  int          m_cnt;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_pend = '0; m_ipc = '0;
    m_instr = NOP; m_valid = 0; m_mis = 0;
    m_wait = 0; m_redir = 0; m_cnt = 0;
  endtask

  task automatic compare();
    check("req", 64'(imem_req), 64'(reset_n));
    check("pc", PC, m_pc);
    check("addr", imem_addr, m_pc);
    check("pc4", PC_plus4, m_pc + 64'd4);
    check("valid", 64'(if_id_valid), 64'(m_valid));
    check("instr", 64'(if_id_instr), 64'(m_instr));
    if (m_valid) check("ifpc", if_id_PC, m_ipc);
    check("misal", 64'(fetch_misalign), 64'(m_mis));
    check("cnt", 64'(flush_count), 64'(m_cnt));
  endtask

  // drive one cycle of inputs and advance the model
  task automatic apply(logic b, logic s, logic r,
                       logic [63:0] np, logic [31:0] rd);
    logic [63:0] tgt;
    logic bub;
    branch_taken = b; stall = s; imem_ready = r;
    next_PC = np; imem_rdata = rd;
    tgt = {np[63:2], 2'b00};
    bub = 0;
    if (b) begin
      if (np[1:0] != 2'b00) m_mis = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end
    if (m_redir) begin
      bub = 1;
      if (b && r) begin m_pc = tgt; m_redir = 0; end
      else if (b) m_pend = tgt;
      else if (r) begin m_pc = m_pend; m_redir = 0; end
    end else if (b) begin
      bub = 1;
      if (r && !m_wait) m_pc = tgt;
      else begin m_redir = 1; m_pend = tgt; end
      m_wait = 0;
    end else if (s) begin
      if (r) m_wait = 0;
    end else if (r) begin
      m_instr = rd; m_ipc = m_pc; m_valid = 1;
      m_pc = np; m_wait = 0;
    end else begin
      bub = 1; m_wait = 1;
    end
    if (bub) begin m_valid = 0; m_instr = NOP; end
  endtask

  task automatic step(logic b, logic s, logic r,
                      logic [63:0] np);
    @(negedge clk);
    compare();
    apply(b, s, r, np, $urandom);
  endtask

  task automatic seq(int n);
    for (int k = 0; k < n; k++) step(0, 0, 1, m_pc + 4);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    model_reset();
    #1 compare();
    @(negedge clk);
    compare();
    reset_n = 1'b1;
    apply(0, 0, 1, m_pc + 4, $urandom);
  endtask

  initial begin
    logic b, s, r;
    logic [63:0] np;
    model_reset();
    @(negedge clk);
    compare();
    @(negedge clk);
    compare();
    reset_n = 1'b1;
    apply(0, 0, 1, 64'h4, $urandom);
    seq(2);
    step(1, 0, 1, 64'h100);
    seq(2);
    step(0, 0, 0, m_pc + 4);
    step(0, 0, 0, m_pc + 4);
    step(0, 0, 0, m_pc + 4);
    seq(1);
    step(0, 0, 0, m_pc + 4);
    step(1, 0, 0, 64'h200);
    step(0, 0, 0, m_pc + 4);
    step(0, 0, 1, m_pc + 4);
    seq(2);
    step(1, 1, 1, 64'h300);
    seq(1);
    step(0, 1, 1, m_pc + 4);
    step(0, 1, 0, m_pc + 4);
    step(0, 1, 1, m_pc + 4);
    seq(1);
    step(1, 0, 1, 64'h102);
    seq(1);
    step(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    seq(2);
    step(0, 0, 0, m_pc + 4);
    step(0, 0, 0, m_pc + 4);
    mid_reset();
    for (int i = 0; i < 3000; i++) begin
      b = ($urandom_range(0, 5) == 0);
      s = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 2) != 0);
      if (b) begin
        np = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) np[1:0] = 2'b00;
      end else if ($urandom_range(0, 9) == 0) begin
        np = {$urandom, $urandom} & ~64'h3;
      end else begin
        np = m_pc + 4;
      end
      step(b, s, r, np);
      if (i == 1500) mid_reset();
    end
    @(negedge clk);
    compare();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
